// File: rtl/durbin_coeff_bank_if.sv
// Handshake and load bus between the Levinson-Durbin engine, the coefficient
// bank and the downstream quantiser.
interface durbin_coeff_bank_if #(
   parameter int COEFF_W = 12,
   parameter int ORDER_W = 4
);
   logic                      iEnable;
   logic                      iNewFrame;
   logic                      iLoad;
   logic [ORDER_W-1:0]        iM;
   logic signed [COEFF_W-1:0] iCoeff;
   logic                      iStart;
   logic [ORDER_W-1:0]        iBestM;
   logic                      iReady;
   logic signed [COEFF_W-1:0] oCoeff;
   logic                      oValid;
   logic                      oLast;
   logic                      oDone;
   logic                      oBusy;

   modport master (
      output iEnable, iNewFrame, iLoad, iM, iCoeff, iStart, iBestM, iReady,
      input  oCoeff, oValid, oLast, oDone, oBusy
   );

   modport slave (
      input  iEnable, iNewFrame, iLoad, iM, iCoeff, iStart, iBestM, iReady,
      output oCoeff, oValid, oLast, oDone, oBusy
   );
endinterface

// File: rtl/durbin_coeff_bank.sv
// Triangular store of LPC coefficient sets for orders 1..MAX_ORDER, with a
// valid/ready unload of the selected order's set.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | accepting loads, waiting for iStart
// BUSY  | presenting coefficient k of order m until the last is taken
module durbin_coeff_bank #(
   parameter int MAX_ORDER = 12,
   parameter int COEFF_W   = 12,
   parameter int ORDER_W   = 4
) (
   input logic                iClock,
   input logic                iReset,
   durbin_coeff_bank_if.slave bus
);
   localparam int NWORDS = MAX_ORDER * (MAX_ORDER + 1) / 2;
   localparam int AW     = $clog2(NWORDS + 1);
   localparam logic [ORDER_W-1:0] MAX_M = ORDER_W'(MAX_ORDER);
   localparam logic [ORDER_W-1:0] ONE_M = ORDER_W'(1);
   localparam logic [ORDER_W-1:0] TWO_M = ORDER_W'(2);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                    state, state_nx;
   logic signed [COEFF_W-1:0] mem [NWORDS];
   logic [ORDER_W-1:0]        ptr [1:MAX_ORDER];
   logic [ORDER_W-1:0]        m_q, m_nx, k_q, k_nx;
   logic signed [COEFF_W-1:0] coeff_q, coeff_nx;
   logic                      valid_q, valid_nx, last_q, last_nx, done_q, done_nx;
   logic                      load_ok, start_ok;
   logic [ORDER_W-1:0]        wr_idx, wr_idx_nx;
   logic [AW-1:0]             wr_addr, start_addr, next_addr;

   // Order m starts at word m(m-1)/2.
   function automatic logic [AW-1:0] base_of(input logic [ORDER_W-1:0] m);
      int mi;
      mi = int'(m);
      return AW'((mi * (mi - 1)) / 2);
   endfunction

   always_comb begin
      load_ok  = bus.iLoad && (state == IDLE) && (bus.iM != '0) && (bus.iM <= MAX_M);
      start_ok = (bus.iBestM != '0) && (bus.iBestM <= MAX_M);
      wr_idx   = '0;
      if (load_ok && !bus.iNewFrame)
         wr_idx = ptr[bus.iM];
      wr_idx_nx  = (wr_idx == bus.iM - ONE_M) ? '0 : wr_idx + ONE_M;
      wr_addr    = base_of(bus.iM) + AW'(wr_idx);
      start_addr = base_of(bus.iBestM);
      next_addr  = base_of(m_q) + AW'(k_q) + AW'(1);
   end

   always_comb begin
      state_nx = state;
      m_nx     = m_q;
      k_nx     = k_q;
      coeff_nx = coeff_q;
      valid_nx = valid_q;
      last_nx  = last_q;
      done_nx  = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.iStart) begin
               if (start_ok) begin
                  state_nx = BUSY;
                  m_nx     = bus.iBestM;
                  k_nx     = '0;
                  valid_nx = 1'b1;
                  last_nx  = (bus.iBestM == ONE_M);
                  // A coincident load into word 0 of the same order is forwarded.
                  coeff_nx = (load_ok && wr_addr == start_addr) ? bus.iCoeff : mem[start_addr];
               end else begin
                  done_nx = 1'b1;
               end
            end
         end
         BUSY: begin
            if (valid_q && bus.iReady) begin
               if (k_q == m_q - ONE_M) begin
                  state_nx = IDLE;
                  valid_nx = 1'b0;
                  last_nx  = 1'b0;
                  done_nx  = 1'b1;
               end else begin
                  k_nx     = k_q + ONE_M;
                  coeff_nx = mem[next_addr];
                  last_nx  = (k_q + TWO_M == m_q);
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state   <= IDLE;
         m_q     <= '0;
         k_q     <= '0;
         coeff_q <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < NWORDS; i++) mem[i] <= '0;
         for (int j = 1; j <= MAX_ORDER; j++) ptr[j] <= '0;
      end else if (bus.iEnable) begin
         state   <= state_nx;
         m_q     <= m_nx;
         k_q     <= k_nx;
         coeff_q <= coeff_nx;
         valid_q <= valid_nx;
         last_q  <= last_nx;
         done_q  <= done_nx;
         if (bus.iNewFrame)
            for (int j = 1; j <= MAX_ORDER; j++) ptr[j] <= '0;
         if (load_ok) begin
            mem[wr_addr] <= bus.iCoeff;
            ptr[bus.iM]  <= wr_idx_nx;
         end
      end
   end

   assign bus.oCoeff = coeff_q;
   assign bus.oValid = valid_q;
   assign bus.oLast  = last_q;
   assign bus.oDone  = done_q;
   assign bus.oBusy  = (state == BUSY);
endmodule

// File: tb/tb_durbin_coeff_bank.sv
// Bench for durbin_coeff_bank: table of unload scenarios, hand-written corner
// sequences and randomized loads/unloads against an array-based model.
module tb_durbin_coeff_bank;
   localparam int MAX_ORDER = 12;
   localparam int COEFF_W   = 12;
   localparam int ORDER_W   = 4;

   logic iClock = 1'b0;
   logic iReset;
   always #5 iClock = ~iClock;

   durbin_coeff_bank_if #(.COEFF_W(COEFF_W), .ORDER_W(ORDER_W)) bus ();

   durbin_coeff_bank #(.MAX_ORDER(MAX_ORDER), .COEFF_W(COEFF_W), .ORDER_W(ORDER_W)) dut (
      .iClock (iClock),
      .iReset (iReset),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   int model_mem [MAX_ORDER+1][MAX_ORDER];
   int model_ptr [MAX_ORDER+1];

   // mode: 0 ready=1, 1 ready on every third cycle, 2 enable low 3 cycles,
   //       3 stray iStart/iLoad while busy, 4 random ready
   typedef struct {
      int best_m;
      int mode;
      int exp_beats;
      int exp_done_cyc;
   } vec_t;
   vec_t vecs [8];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge iClock);
      #1;
   endtask

   function automatic void model_load(input int m, input int c, input bit nf);
      if (nf) foreach (model_ptr[i]) model_ptr[i] = 0;
      if (m >= 1 && m <= MAX_ORDER) begin
         model_mem[m][model_ptr[m]] = c;
         model_ptr[m] = (model_ptr[m] + 1) % m;
      end
   endfunction

   function automatic void model_clear();
      foreach (model_mem[i, j]) model_mem[i][j] = 0;
      foreach (model_ptr[i]) model_ptr[i] = 0;
   endfunction

   task automatic load(input int m, input int c, input bit nf);
      bus.iLoad     = 1'b1;
      bus.iM        = ORDER_W'(m);
      bus.iCoeff    = COEFF_W'(c);
      bus.iNewFrame = nf;
      step();
      bus.iLoad     = 1'b0;
      bus.iNewFrame = 1'b0;
      model_load(m, c, nf);
   endtask

   task automatic unload(input int m, input int mode, input int exp_beats, input int exp_done_cyc);
      int  beats;
      int  cyc;
      bit  done_seen;
      bit  legal;
      legal     = (m >= 1 && m <= MAX_ORDER);
      beats     = 0;
      cyc       = 0;
      done_seen = 1'b0;
      bus.iStart  = 1'b1;
      bus.iBestM  = ORDER_W'(m);
      bus.iReady  = 1'b1;
      bus.iEnable = 1'b1;
      step();
      bus.iStart = 1'b0;
      while (cyc < 400 && !done_seen) begin
         bus.iReady  = 1'b1;
         bus.iEnable = 1'b1;
         bus.iLoad   = 1'b0;
         bus.iStart  = 1'b0;
         case (mode)
            1: bus.iReady = (cyc % 3 == 0);
            2: bus.iEnable = !(cyc >= 2 && cyc <= 4);
            3: if (cyc == 1) begin
                  bus.iLoad   = 1'b1;
                  bus.iM      = ORDER_W'(m);
                  bus.iCoeff  = COEFF_W'(999);
                  bus.iStart  = 1'b1;
                  bus.iBestM  = ORDER_W'(1);
               end
            4: bus.iReady = 1'($urandom_range(1));
            default: ;
         endcase
         if (bus.oDone) begin
            done_seen = 1'b1;
            chk("beats", beats, exp_beats);
            chk("valid_at_done", int'(bus.oValid), 0);
            chk("last_at_done", int'(bus.oLast), 0);
            chk("busy_at_done", int'(bus.oBusy), 0);
            if (exp_done_cyc >= 0) chk("done_cycle", cyc, exp_done_cyc);
         end else if (legal) begin
            chk("valid", int'(bus.oValid), 1);
            chk("busy", int'(bus.oBusy), 1);
            if (beats < m) begin
               chk("coeff", int'($signed(bus.oCoeff)), model_mem[m][beats]);
               chk("last", int'(bus.oLast), int'(beats == m - 1));
            end
            if (bus.oValid && bus.iReady && bus.iEnable) beats++;
         end else begin
            chk("illegal_valid", int'(bus.oValid), 0);
         end
         step();
         cyc++;
      end
      if (!done_seen) chk("done_timeout", 0, 1);
      bus.iReady  = 1'b0;
      bus.iEnable = 1'b1;
      bus.iLoad   = 1'b0;
      bus.iStart  = 1'b0;
      chk("done_single_pulse", int'(bus.oDone), 0);
      chk("valid_after", int'(bus.oValid), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{best_m: 3,  mode: 0, exp_beats: 3,  exp_done_cyc: 3};
      vecs[1] = '{best_m: 12, mode: 1, exp_beats: 12, exp_done_cyc: 34};
      vecs[2] = '{best_m: 2,  mode: 0, exp_beats: 2,  exp_done_cyc: 2};
      vecs[3] = '{best_m: 5,  mode: 0, exp_beats: 5,  exp_done_cyc: 5};
      vecs[4] = '{best_m: 5,  mode: 3, exp_beats: 5,  exp_done_cyc: 5};
      vecs[5] = '{best_m: 5,  mode: 2, exp_beats: 5,  exp_done_cyc: 8};
      vecs[6] = '{best_m: 0,  mode: 0, exp_beats: 0,  exp_done_cyc: 0};
      vecs[7] = '{best_m: 13, mode: 0, exp_beats: 0,  exp_done_cyc: 0};

      model_clear();
      bus.iEnable = 1'b1; bus.iNewFrame = 1'b0; bus.iLoad = 1'b0; bus.iM = '0;
      bus.iCoeff = '0; bus.iStart = 1'b0; bus.iBestM = '0; bus.iReady = 1'b0;
      iReset = 1'b1;
      step();
      step();
      iReset = 1'b0;
      chk("rst_coeff", int'($signed(bus.oCoeff)), 0);
      chk("rst_valid", int'(bus.oValid), 0);
      chk("rst_last", int'(bus.oLast), 0);
      chk("rst_done", int'(bus.oDone), 0);
      chk("rst_busy", int'(bus.oBusy), 0);

      load(3, 5, 0); load(3, -7, 0); load(3, 9, 0);
      for (int i = 1; i <= 12; i++) load(12, i, 0);
      load(2, 4, 0); load(2, 6, 0); load(2, 8, 0);
      for (int i = 0; i < 5; i++) load(5, int'($urandom_range(4095)) - 2048, 0);

      foreach (vecs[v]) unload(vecs[v].best_m, vecs[v].mode, vecs[v].exp_beats, vecs[v].exp_done_cyc);

      load(2, 1, 1);
      load(2, 2, 0);
      unload(2, 0, 2, 2);

      // reset in the middle of an order-6 unload
      for (int i = 0; i < 6; i++) load(6, 100 + i, 0);
      bus.iStart = 1'b1; bus.iBestM = ORDER_W'(6); bus.iReady = 1'b1;
      step();
      bus.iStart = 1'b0;
      step();
      bus.iReady = 1'b0;
      iReset = 1'b1;
      step();
      iReset = 1'b0;
      model_clear();
      chk("mid_rst_coeff", int'($signed(bus.oCoeff)), 0);
      chk("mid_rst_valid", int'(bus.oValid), 0);
      chk("mid_rst_last", int'(bus.oLast), 0);
      chk("mid_rst_done", int'(bus.oDone), 0);
      chk("mid_rst_busy", int'(bus.oBusy), 0);
      step();
      chk("mid_rst_no_done", int'(bus.oDone), 0);
      unload(6, 0, 6, 6);

      for (int r = 0; r < 40; r++) begin
         int n_ld;
         int bm;
         n_ld = int'($urandom_range(15));
         for (int i = 0; i < n_ld; i++)
            load(int'($urandom_range(15)), int'($urandom_range(4095)) - 2048,
                 ($urandom_range(7) == 0));
         bm = int'($urandom_range(13));
         unload(bm, 4, (bm >= 1 && bm <= MAX_ORDER) ? bm : 0, (bm >= 1 && bm <= MAX_ORDER) ? -1 : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
